// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: MEM-stage data-memory access sequencer.
// Latches the EX/MEM load/store request, runs a req/ready handshake on the
// data-memory port, stalls the pipeline until completion and returns the
// aligned, sign/zero-extended load result.
// Optional feature macro: DM_TIMEOUT_EN (abort an access stuck in REQ).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a load/store; latches the request when one appears
// REQ   | dm_req held high with stable address/data until dm_ready
// DONE  | access finished; pipeline released; load_valid/dm_err pulse
module dm_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MEM_MemRead,
    input  logic        MEM_write_signal,
    input  logic [3:0]  MEM_MemWrite,
    input  logic [31:0] MEM_ALU_out,
    input  logic [31:0] MEM_memory_in,
    input  logic [2:0]  MEM_funct3,
    input  logic        flush,
    input  logic        dm_ready,
    input  logic [31:0] dm_rdata,
    output logic        dm_req,
    output logic        dm_oe,
    output logic [3:0]  dm_web,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic        dm_stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        dm_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        req_q, req_d;
    logic        oe_q, oe_d;
    logic [3:0]  web_q, web_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        is_load_q, is_load_d;
    logic        drop_q, drop_d;
    logic [31:0] load_data_q, load_data_d;
    logic        load_valid_q, load_valid_d;
    logic        err_q, err_d;
    logic        access;

`ifdef DM_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    // Byte/half selection by the latched low address bits, then extension by load type.
    function automatic logic [31:0] align_load(input logic [31:0] rdata,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{lane, 3'b000} +: 8];
        h = lane[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  align_load = {{24{b[7]}}, b};
            3'b100:  align_load = {24'h0, b};
            3'b001:  align_load = {{16{h[15]}}, h};
            3'b101:  align_load = {16'h0, h};
            default: align_load = rdata;
        endcase
    endfunction

    assign access = MEM_MemRead | MEM_write_signal;

    // Pipeline hold: combinational in IDLE so the request stalls in its own cycle.
    always_comb begin
        dm_stall = 1'b0;
        if (!reset) begin
            case (state_q)
                S_IDLE:  dm_stall = access & ~flush;
                S_REQ:   dm_stall = 1'b1;
                default: dm_stall = 1'b0;
            endcase
        end
    end

    // Next-state and registered-output computation for the access sequence.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        oe_d         = oe_q;
        web_d        = web_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        funct3_d     = funct3_q;
        is_load_d    = is_load_q;
        drop_d       = drop_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        err_d        = 1'b0;
`ifdef DM_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (access && !flush) begin
                    // Store wins when both request bits are set.
                    state_d   = S_REQ;
                    req_d     = 1'b1;
                    is_load_d = ~MEM_write_signal;
                    oe_d      = ~MEM_write_signal;
                    web_d     = MEM_write_signal ? MEM_MemWrite : 4'hf;
                    addr_d    = MEM_ALU_out;
                    wdata_d   = MEM_memory_in;
                    funct3_d  = MEM_funct3;
                    drop_d    = 1'b0;
`ifdef DM_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            S_REQ: begin
                // A flush cannot abandon the bus cycle; it only suppresses the result.
                drop_d = drop_q | flush;
                if (dm_ready) begin
                    state_d      = S_DONE;
                    req_d        = 1'b0;
                    oe_d         = 1'b0;
                    web_d        = 4'hf;
                    if (is_load_q) begin
                        load_data_d = align_load(dm_rdata, addr_q[1:0], funct3_q);
                    end
                    load_valid_d = is_load_q & ~(drop_q | flush);
                end
`ifdef DM_TIMEOUT_EN
                else if (int'(cnt_q) >= TIMEOUT_CYCLES - 1) begin
                    state_d     = S_DONE;
                    req_d       = 1'b0;
                    oe_d        = 1'b0;
                    web_d       = 4'hf;
                    load_data_d = '0;
                    err_d       = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_DONE: begin
                // The finished instruction is still presented here; never re-accept it.
                state_d = S_IDLE;
                drop_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
                oe_d    = 1'b0;
                web_d   = 4'hf;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            req_q        <= 1'b0;
            oe_q         <= 1'b0;
            web_q        <= 4'hf;
            addr_q       <= '0;
            wdata_q      <= '0;
            funct3_q     <= '0;
            is_load_q    <= 1'b0;
            drop_q       <= 1'b0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            err_q        <= 1'b0;
`ifdef DM_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            oe_q         <= oe_d;
            web_q        <= web_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            funct3_q     <= funct3_d;
            is_load_q    <= is_load_d;
            drop_q       <= drop_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            err_q        <= err_d;
`ifdef DM_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign dm_req     = req_q;
    assign dm_oe      = oe_q;
    assign dm_web     = web_q;
    assign dm_addr    = {addr_q[31:2], 2'b00};
    assign dm_wdata   = wdata_q;
    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign dm_err     = err_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Testbench for dm_access_ctrl: randomized load/store stream with a
// queue-based scoreboard for bus beats and load results.
module tb_dm_access_ctrl;

`ifdef DM_TIMEOUT_EN
    localparam int TMO    = 8;
    localparam bit TMO_EN = 1'b1;
`else
    localparam int TMO    = 255;
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        MEM_MemRead, MEM_write_signal;
    logic [3:0]  MEM_MemWrite;
    logic [31:0] MEM_ALU_out, MEM_memory_in;
    logic [2:0]  MEM_funct3;
    logic        flush;
    logic        dm_ready = 1'b0;
    logic [31:0] dm_rdata = '0;
    logic        dm_req, dm_oe, dm_stall, load_valid, dm_err;
    logic [3:0]  dm_web;
    logic [31:0] dm_addr, dm_wdata, load_data;

    dm_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .MEM_MemRead(MEM_MemRead), .MEM_write_signal(MEM_write_signal),
        .MEM_MemWrite(MEM_MemWrite), .MEM_ALU_out(MEM_ALU_out),
        .MEM_memory_in(MEM_memory_in), .MEM_funct3(MEM_funct3),
        .flush(flush), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .dm_req(dm_req), .dm_oe(dm_oe), .dm_web(dm_web), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_stall(dm_stall), .load_data(load_data),
        .load_valid(load_valid), .dm_err(dm_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  web;
        logic        oe;
    } bus_t;

    bus_t        bq[$];
    logic [31:0] lvq[$];
    int          checks = 0;
    int          errors = 0;
    int          err_cnt = 0;
    int          exp_err_cnt = 0;
    int          cur_waits = 0;
    logic [31:0] cur_rdata = '0;
    int          rcnt = 0;
    logic [31:0] last_ld = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: pick the addressed byte/half by plain arithmetic, extend with $signed.
    function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [31:0] addr,
                                             input logic [2:0] f3);
        logic [31:0] bsh, hsh;
        logic [7:0]  b;
        logic [15:0] h;
        bsh = rdata >> (8 * addr[1:0]);
        hsh = rdata >> (16 * addr[1]);
        b = bsh[7:0];
        h = hsh[15:0];
        case (f3)
            3'd0:    return 32'($signed(b));
            3'd4:    return 32'(b);
            3'd1:    return 32'($signed(h));
            3'd5:    return 32'(h);
            default: return rdata;
        endcase
    endfunction

    // Memory responder, bus scoreboard and load-result monitor.
    always @(negedge clk) begin
        if (dm_req === 1'b1) begin
            dm_ready = (rcnt == cur_waits);
            dm_rdata = dm_ready ? cur_rdata : $urandom();
            rcnt++;
        end else begin
            rcnt = 0;
            dm_ready = ($urandom_range(0, 3) == 0);
            dm_rdata = $urandom();
        end
        if (dm_req === 1'b1) begin
            if (bq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_req actual=dm_req=1 expected=no request t=%0t", $time);
            end else begin
                chk("bus_addr", dm_addr, bq[0].addr);
                chk("bus_wdata", dm_wdata, bq[0].wdata);
                chk("bus_web", {28'h0, dm_web}, {28'h0, bq[0].web});
                chk("bus_oe", {31'h0, dm_oe}, {31'h0, bq[0].oe});
                if (dm_ready) void'(bq.pop_front());
            end
        end
        if (load_valid === 1'b1) begin
            if (lvq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_load_valid actual=1 expected=0 t=%0t", $time);
            end else begin
                chk("load_data_sb", load_data, lvq.pop_front());
            end
        end
        if (dm_err === 1'b1) err_cnt++;
    end

    task automatic set_idle();
        MEM_MemRead      = 1'b0;
        MEM_write_signal = 1'b0;
        MEM_MemWrite     = 4'($urandom());
        MEM_ALU_out      = $urandom();
        MEM_memory_in    = $urandom();
        MEM_funct3       = 3'($urandom());
        flush            = 1'b0;
    endtask

    // One pipeline instruction; entered and left #1 after a posedge.
    // fmode: 0 none, 1 flush in REQ cycle fk (0-based), 2 flush while in IDLE.
    task automatic do_txn(input bit rd, input bit wr, input logic [3:0] web,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, input logic [31:0] rdata,
                          input int waits, input int fmode, input int fk);
        bit tmo, exp_lv;
        int last_req;
        MEM_MemRead = rd; MEM_write_signal = wr; MEM_MemWrite = web;
        MEM_ALU_out = addr; MEM_memory_in = wdata; MEM_funct3 = f3; flush = 1'b0;
        cur_waits = waits; cur_rdata = rdata;
        if (fmode == 2) begin
            flush = 1'b1;
            @(negedge clk);
            chk("flushed_idle_stall", {31'h0, dm_stall}, 0);
            @(posedge clk); #1;
            set_idle();
            @(negedge clk);
            chk("flushed_idle_req", {31'h0, dm_req}, 0);
            @(posedge clk); #1;
            return;
        end
        tmo = TMO_EN && (waits >= TMO);
        last_req = tmo ? TMO : waits + 1;
        bq.push_back('{addr: {addr[31:2], 2'b00}, wdata: wdata,
                       web: wr ? web : 4'hf, oe: !wr});
        exp_lv = !wr && (fmode == 0) && !tmo;
        if (!wr) last_ld = tmo ? 32'h0 : ref_load(rdata, addr, f3);
        else if (tmo) last_ld = 32'h0;
        if (exp_lv) lvq.push_back(last_ld);
        for (int i = 0; i <= last_req + 1; i++) begin
            @(negedge clk);
            chk("stall", {31'h0, dm_stall}, {31'h0, i <= last_req});
            chk("req", {31'h0, dm_req}, {31'h0, i >= 1 && i <= last_req});
            if (i == last_req + 1) begin
                chk("done_load_valid", {31'h0, load_valid}, {31'h0, exp_lv});
                chk("done_load_data", load_data, last_ld);
                chk("done_err", {31'h0, dm_err}, {31'h0, tmo});
            end
            @(posedge clk); #1;
            flush = (fmode == 1) && (i + 1 == fk + 1);
            if (i + 1 == last_req + 1) flush = 1'b0;
        end
        if (tmo) begin
            exp_err_cnt++;
            if (bq.size() != 0) void'(bq.pop_front());
        end
        set_idle();
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("idle_stall", {31'h0, dm_stall}, 0);
            chk("idle_req", {31'h0, dm_req}, 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        set_idle();
        MEM_MemRead = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_stall", {31'h0, dm_stall}, 0);
        chk("rst_req", {31'h0, dm_req}, 0);
        chk("rst_oe", {31'h0, dm_oe}, 0);
        chk("rst_web", {28'h0, dm_web}, 32'hf);
        chk("rst_addr", dm_addr, 0);
        chk("rst_wdata", dm_wdata, 0);
        chk("rst_load_data", load_data, 0);
        chk("rst_load_valid", {31'h0, load_valid}, 0);
        chk("rst_err", {31'h0, dm_err}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        set_idle();
        idle_cycles(2);

        // Directed cases.
        do_txn(1, 0, 4'hf, 32'h103, 32'h0, 3'b000, 32'h80112233, 0, 0, 0);
        do_txn(1, 0, 4'hf, 32'h202, 32'h0, 3'b101, 32'hBEEF1234, 0, 0, 0);
        do_txn(0, 1, 4'b1011, 32'h301, 32'h00AB0000, 3'b000, 32'h0, 4, 0, 0);
        do_txn(1, 0, 4'hf, 32'h400, 32'h0, 3'b010, 32'h12345678, 3, 1, 1);
        do_txn(1, 0, 4'hf, 32'h504, 32'h0, 3'b010, 32'hCAFEF00D, 0, 0, 0);
        do_txn(1, 0, 4'hf, 32'h509, 32'h0, 3'b001, 32'h8001F7FF, 1, 0, 0);
        do_txn(1, 1, 4'b0000, 32'h600, 32'hDEADBEEF, 3'b010, 32'h0, 0, 0, 0);
        do_txn(1, 0, 4'hf, 32'h700, 32'h0, 3'b010, 32'h0, 0, 2, 0);
        idle_cycles(1);

        // Reset in the middle of REQ.
        cur_waits = 20;
        MEM_MemRead = 1'b1; MEM_ALU_out = 32'h800; MEM_funct3 = 3'b010;
        bq.push_back('{addr: 32'h800, wdata: MEM_memory_in, web: 4'hf, oe: 1'b1});
        @(posedge clk); #1;
        set_idle();
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_stall", {31'h0, dm_stall}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        bq.delete();
        last_ld = 32'h0;
        @(negedge clk);
        chk("rst_mid_req", {31'h0, dm_req}, 0);
        chk("rst_mid_load_valid", {31'h0, load_valid}, 0);
        @(posedge clk); #1;

        if (TMO_EN) do_txn(1, 0, 4'hf, 32'h900, 32'h0, 3'b010, 32'h1, 1000, 0, 0);

        // Randomized stream.
        for (int n = 0; n < 60; n++) begin
            bit wr, rd;
            int waits, fmode, sel;
            wr = ($urandom_range(0, 2) == 0);
            rd = wr ? 1'($urandom()) : 1'b1;
            waits = $urandom_range(0, 4);
            sel = $urandom_range(0, 9);
            fmode = (sel < 7) ? 0 : ((sel < 9) ? 1 : 2);
            do_txn(rd, wr, 4'($urandom()), $urandom(), $urandom(), 3'($urandom()),
                   $urandom(), waits, fmode, $urandom_range(0, waits));
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 2));
        end

        idle_cycles(3);
        chk("bus_queue_drained", 32'(bq.size()), 0);
        chk("load_queue_drained", 32'(lvq.size()), 0);
        chk("err_pulse_count", 32'(err_cnt), 32'(exp_err_cnt));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/dm_access_ctrl.md
# dm_access_ctrl

Data-memory access sequencer for the MEM stage. Takes the load/store request held in the EX/MEM pipeline register, runs a request/ready handshake on the data-memory port, and drives `dm_stall` so the pipeline holds until the access completes. Returns load data already byte/half-aligned and sign- or zero-extended per `funct3`.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum number of REQ cycles before the access is aborted. Used only with `DM_TIMEOUT_EN`.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `MEM_MemRead` in 1: load request.
- `MEM_write_signal` in 1: store request.
- `MEM_MemWrite` in 4: active-low byte write enables; 4'hf means no bytes.
- `MEM_ALU_out` in 32: byte address.
- `MEM_memory_in` in 32: store data, already lane-shifted.
- `MEM_funct3` in 3: load type.
- `flush` in 1: discard the current or pending access result.
- `dm_ready` in 1: memory accepted and completed the access.
- `dm_rdata` in 32: read data, valid with `dm_ready`.
- `dm_req` out 1: access request.
- `dm_oe` out 1: read strobe.
- `dm_web` out 4: active-low byte write enables.
- `dm_addr` out 32: word address; `[1:0]` forced to 0.
- `dm_wdata` out 32: write data.
- `dm_stall` out 1: hold the pipeline.
- `load_data` out 32: aligned and extended load result.
- `load_valid` out 1: one-cycle pulse; `load_data` is valid.
- `dm_err` out 1: one-cycle pulse on timeout (tied 0 without `DM_TIMEOUT_EN`).

## Operation
- FSM states: IDLE, REQ, DONE.
- Access condition: `MEM_MemRead | MEM_write_signal`. If both are set, the store wins.
- **IDLE**
  - With an access and `flush`=0: latch address, data, `dm_web`, `dm_oe` and `funct3`; go to REQ.
  - `dm_stall` is combinational: `access & ~flush`.
- **REQ**
  - `dm_req`=1 and `dm_stall`=1.
  - Loads drive `dm_oe`=1 and `dm_web`=4'hf.
  - Stores drive `dm_oe`=0 and `dm_web`=latched `MEM_MemWrite`.
  - On `dm_ready`: register the aligned load result and go to DONE.
  - `flush` in REQ sets a drop flag. The bus transaction still completes; it is never abandoned.
- **DONE**
  - `dm_stall`=0, so the pipeline advances at the end of this cycle.
  - `load_valid` = latched-load & ~drop. Clear the drop flag.
  - Go to IDLE.
  - DONE never accepts a new access. The instruction still visible during DONE is the completed one and must not be reissued.
- Load alignment uses latched `addr[1:0]`:
  - LB (000) / LBU (100): byte `addr[1:0]`, sign- or zero-extended.
  - LH (001) / LHU (101): half `addr[1]`, sign- or zero-extended.
  - LW (010) and all other codes: full word.
- On stores, `load_data` holds its previous value.

## Timing
- **Reset values:** state IDLE; `dm_req`, `dm_oe`, `load_valid`, `dm_err` = 0; `dm_web`=4'hf; `dm_addr`, `dm_wdata`, `load_data` = 0; drop flag 0.
- `dm_stall` reflects reset immediately: 0 while `reset`=1.
- **Minimum access:**
  - Cycle 0: IDLE sees the access.
  - Cycle 1: REQ, with `dm_ready`=1.
  - Cycle 2: DONE.
  - The pipeline advances at the end of cycle 2, so `dm_stall` is high for 2 cycles.
- **Wait states:** each cycle of `dm_ready`=0 in REQ adds one stall cycle. `dm_req`, `dm_addr` and `dm_wdata` stay stable until `dm_ready`.
- **Back-to-back accesses:** the next access is recognised in the cycle after DONE. Issue rate is one access per 3 cycles.
- **Reset mid-REQ:** return to IDLE next edge and drop `dm_req`. No `load_valid`.
- `dm_ready` outside REQ is ignored.

## Configuration
- Macro: `DM_TIMEOUT_EN`.
- **Defined:**
  - An 8+ bit counter clears on entering REQ and increments each REQ cycle.
  - When the count reaches `TIMEOUT_CYCLES` with no `dm_ready`: go to DONE, pulse `dm_err`, force `load_data`=0 and `load_valid`=0.
- **Undefined:** no counter; REQ waits indefinitely; `dm_err` is tied to 0.

## Test plan
- **LB, sign-extended:** LB at addr 0x103, `dm_rdata`=0x80112233, ready on the first REQ cycle → `load_data`=0xFFFFFF80, `load_valid` in cycle 2, `dm_stall` high in cycles 0–1, `dm_addr`=0x100.
- **LHU, zero-extended:** LHU at addr 0x202, `dm_rdata`=0xBEEF1234 → `load_data`=0x0000BEEF.
- **SB with wait states:** SB with `MEM_MemWrite`=4'b1011 and data 0x00AB0000, `dm_ready` delayed 4 cycles → `dm_req`/`dm_web`/`dm_wdata` stable for 5 REQ cycles, `dm_oe`=0, no `load_valid`.
- **Flush mid-access:** `flush` in the 2nd REQ cycle of an LW → transaction completes on `dm_ready`, DONE with `load_valid`=0.
- **Back-to-back:** two loads back-to-back → the second `dm_req` rises in the cycle after DONE, and there is exactly one `dm_req` pulse train per instruction.
- **Timeout (with `DM_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8):** `dm_ready` never asserted → `dm_err` pulses after 8 REQ cycles, `load_data`=0, `dm_stall` releases in DONE.
